// File: rtl/uart_tx_pkg.sv
// Shared state encodings and line levels for the UART transmit frame sequencer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Bit counter must hold the value width itself so the overrun check can fire.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between data source, serializer and the UART frame sequencer.
interface uart_tx_ctrl_if #(
    parameter int width = 8
);
    logic             Data_valid;
    logic [width-1:0] P_Data;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             Ser_data;
    logic             Ser_done;
    logic             Ser_EN;
    logic             Ser_load;
    logic             TX_OUT;
    logic             Busy;
    logic             Frame_err;

    modport slave (
        input  Data_valid, P_Data, PAR_EN, PAR_TYP, Ser_data, Ser_done,
        output Ser_EN, Ser_load, TX_OUT, Busy, Frame_err
    );

    modport master (
        output Data_valid, P_Data, PAR_EN, PAR_TYP, Ser_data, Ser_done,
        input  Ser_EN, Ser_load, TX_OUT, Busy, Frame_err
    );
endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity of the payload; odd mode inverts the even-parity bit.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int width = 8
) (
    input  logic [width-1:0] Data,
    input  logic             PAR_TYP,
    output logic             par_bit
);

    assign par_bit = (^Data) ^ (PAR_TYP == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: start / data (from serializer) / optional parity / stop on TX_OUT.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int width = 8
) (
    input  logic          CLK,
    input  logic          Reset,
    uart_tx_ctrl_if.slave bus
);

    localparam int CW = bit_cnt_width(width);

    state_e          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            par_bit_q, par_bit_d;
    logic            par_en_q, par_en_d;
    logic            par_bit_w;
    logic            accept;
    logic            ser_en;
    logic            frame_err;
    logic            tx_out;

    parity_calc #(.width(width)) u_parity_calc (
        .Data    (bus.P_Data),
        .PAR_TYP (bus.PAR_TYP),
        .par_bit (par_bit_w)
    );

    // Reset gates accept so a coincident request never pulses Ser_load.
    assign accept = bus.Data_valid && !Reset &&
                    ((state_q == ST_IDLE) || (state_q == ST_STOP));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        ser_en    = 1'b0;
        frame_err = 1'b0;
        tx_out    = STOP_LVL;

        if (accept) begin
            par_bit_d = par_bit_w;
            par_en_d  = bus.PAR_EN;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                tx_out    = START_LVL;
                ser_en    = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                tx_out = bus.Ser_data;
                ser_en = !bus.Ser_done;
                if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                if (bus.Ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else if (bit_cnt_q == CW'(width)) begin
                    // Serializer overran its word: drop the frame and idle the line.
                    frame_err = 1'b1;
                    state_d   = ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_out  = par_bit_q;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                state_d = accept ? ST_START : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Ser_EN    = ser_en;
    assign bus.Ser_load  = accept;
    assign bus.TX_OUT    = tx_out;
    assign bus.Frame_err = frame_err;
    assign bus.Busy      = (state_q == ST_START) || (state_q == ST_DATA) ||
                           (state_q == ST_PARITY);

endmodule
